// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end:
// memory command encodings and fetch-unit state type.
package cpu_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Shared memory port bundle.
// master: mem_cmd/mem_addr out, mem_ready/read_data in.
interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 16
);
    logic [1:0]         mem_cmd;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [INSTR_W-1:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        input  mem_ready,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        output mem_ready,
        output read_data
    );
endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter: enabled register, async reset to RESET_PC.
// Ports: clk, reset, en, br_sel, br_target in; pc out.
module pc_reg #(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              br_sel,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Increment wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = br_sel ? br_target : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RST_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns PC, IR and the shared memory port (mem).
// Ports: clk, reset, mem (master), ir/ir_valid, data_* access
// port, instr_done/br_taken/br_target/halt, pc, halted.
// Optional PC_FETCH_INSTRET_EN adds 32-bit instret output.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_unit_if.master    mem,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               data_req,
    input  logic               data_we,
    input  logic [ADDR_W-1:0]  data_addr,
    output logic               data_ready,
    input  logic               instr_done,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
`ifdef PC_FETCH_INSTRET_EN
    ,
    output logic [31:0]        instret
`endif
);
    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic               pc_en;
    logic               pc_br;
    logic [1:0]         cmd;
    logic [ADDR_W-1:0]  addr;
    logic               dready;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .en        (pc_en),
        .br_sel    (pc_br),
        .br_target (br_target),
        .pc        (pc)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_en   = 1'b0;
        pc_br   = 1'b0;
        cmd     = MNONE;
        addr    = pc;
        dready  = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                cmd = MREAD;
                if (mem.mem_ready) begin
                    ir_d    = mem.read_data;
                    pc_en   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Data port follows the execute stage combinationally.
                if (data_req) begin
                    addr   = data_addr;
                    cmd    = data_we ? MWRITE : MREAD;
                    dready = mem.mem_ready;
                end
                // Retire even if a data access is still pending.
                if (instr_done) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        if (br_taken) begin
                            pc_en = 1'b1;
                            pc_br = 1'b1;
                        end
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef PC_FETCH_INSTRET_EN
    logic        retire;
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    assign retire = (state_q == S_EXEC) && instr_done;

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

    assign mem.mem_cmd  = cmd;
    assign mem.mem_addr = addr;
    assign data_ready   = dready;
    assign ir           = ir_q;
    // IR stays valid through halt: halt is only entered from EXEC.
    assign ir_valid     = (state_q == S_EXEC) || (state_q == S_HALT);
    assign halted       = (state_q == S_HALT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized + directed bench for pc_fetch_unit against a
// phase-level reference model.
module tb_pc_fetch_unit;

    localparam int AW  = 9;
    localparam int IW  = 16;
    localparam int RPC = 0;

    localparam int P_RST  = 0;
    localparam int P_FET  = 1;
    localparam int P_EXE  = 2;
    localparam int P_HALT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic          data_ready;
    logic          instr_done = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic          halt = 1'b0;
    logic [AW-1:0] pc;
    logic          halted;
`ifdef PC_FETCH_INSTRET_EN
    logic [31:0]   instret;
`endif

    pc_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) mem_if ();

    pc_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .RESET_PC (RPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mem_if),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_ready (data_ready),
        .instr_done (instr_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt       (halt),
        .pc         (pc),
        .halted     (halted)
`ifdef PC_FETCH_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase, pc, ir, retired count.
    int          m_ph;
    int          m_pc;
    logic [15:0] m_ir;
    longint      m_ret;
    int          m_hcnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph   = P_RST;
        m_pc   = RPC;
        m_ir   = 16'h0;
        m_ret  = 0;
        m_hcnt = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] e_cmd;
        logic [31:0] e_addr;
        logic        e_dr;
        e_cmd  = 0;
        e_addr = 32'(m_pc);
        e_dr   = 1'b0;
        if (m_ph == P_FET) begin
            e_cmd = 1;
        end else if (m_ph == P_EXE && data_req) begin
            e_cmd  = data_we ? 2 : 1;
            e_addr = 32'(data_addr);
            e_dr   = mem_if.mem_ready;
        end
        chk("mem_cmd", 32'(mem_if.mem_cmd), e_cmd);
        if (m_ph == P_FET || m_ph == P_EXE) begin
            chk("mem_addr", 32'(mem_if.mem_addr), e_addr);
        end
        chk("data_ready", 32'(data_ready), 32'(e_dr));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_valid", 32'(ir_valid),
            32'(m_ph == P_EXE || m_ph == P_HALT));
        chk("halted", 32'(halted), 32'(m_ph == P_HALT));
        chk("pc", 32'(pc), 32'(m_pc));
`ifdef PC_FETCH_INSTRET_EN
        chk("instret", instret, m_ret[31:0]);
`endif
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        case (m_ph)
            P_RST: m_ph = P_FET;
            P_FET: begin
                if (mem_if.mem_ready) begin
                    m_ir = mem_if.read_data;
                    m_pc = (m_pc + 1) % (1 << AW);
                    m_ph = P_EXE;
                end
            end
            P_EXE: begin
                if (instr_done) begin
                    m_ret++;
                    if (halt) begin
                        m_ph = P_HALT;
                    end else begin
                        if (br_taken) m_pc = int'(br_target);
                        m_ph = P_FET;
                    end
                end
            end
            default: m_hcnt++;
        endcase
    endtask

    task automatic cyc(input logic rdy, input logic [15:0] rd,
                       input logic req, input logic we,
                       input logic [8:0] da, input logic dn,
                       input logic br, input logic [8:0] tg,
                       input logic hl);
        @(negedge clk);
        mem_if.mem_ready = rdy;
        mem_if.read_data = rd;
        data_req   = req;
        data_we    = we;
        data_addr  = da;
        instr_done = dn;
        br_taken   = br;
        br_target  = tg;
        halt       = hl;
        #1;
        check_outputs();
        model_step();
    endtask

    // Reset asserted mid-cycle: outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        model_step();
    endtask

    task automatic fetch_wait(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b0);
        end
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.read_data = '0;
        model_reset();
        do_reset();

        // Streaming fetch with zero wait states.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 16'hA0F1, 1'b0, 1'b0, 9'h0, 1'b1, 1'b0, 9'h0, 1'b0);
        end

        // Three wait states, then fetch completes.
        fetch_wait(3);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b0);

        // Data write to top of memory, then branch to 0x040.
        cyc(1'b1, 16'h0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 9'h0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 9'h0AA, 1'b0, 1'b0, 9'h0, 1'b0);
        cyc(1'b1, 16'h0, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b1, 9'h040, 1'b0);
        cyc(1'b1, 16'h5555, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b0);

        // Branch to 0x1FF; fetch there wraps PC to 0.
        cyc(1'b1, 16'h0, 1'b0, 1'b0, 9'h0, 1'b1, 1'b1, 9'h1FF, 1'b0);
        cyc(1'b1, 16'h7E7E, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b0);

        // Branch together with halt: halt wins.
        cyc(1'b1, 16'h0, 1'b0, 1'b0, 9'h0, 1'b1, 1'b1, 9'h040, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'hFFFF, 1'b1, 1'b1, 9'h3, 1'b1, 1'b1, 9'h7, 1'b0);
        end

        // Reset while a fetch is waiting.
        do_reset();
        fetch_wait(2);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ((m_ph == P_HALT && m_hcnt > 3) ||
                $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 6,
                    16'($urandom),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    9'($urandom),
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 3,
                    ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom),
                    $urandom_range(0, 15) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
